// File: rtl/rng_cal_pkg.sv
// Shared definitions for the TRNG calibration FSM and the configuration scan transmitter:
// state encoding, code geometry and the ordering of trim codes inside the shift word.
package rng_cal_pkg;

    localparam int CODE_W    = 4;
    localparam int NCODES    = 6;
    localparam int CHAIN_LEN = CODE_W * NCODES;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } cal_state_t;

    // Code slot inside the shift word; slot 5 sits at the MSB end and is shifted first.
    localparam int SLOT_NCONF1   = 5;
    localparam int SLOT_NCONF0   = 4;
    localparam int SLOT_PCONF1   = 3;
    localparam int SLOT_PCONF0   = 2;
    localparam int SLOT_CLKCONF1 = 1;
    localparam int SLOT_CLKCONF0 = 0;

    function automatic logic [CHAIN_LEN-1:0] pack_word(
        input logic [CODE_W-1:0] nconf1,
        input logic [CODE_W-1:0] nconf0,
        input logic [CODE_W-1:0] pconf1,
        input logic [CODE_W-1:0] pconf0,
        input logic [CODE_W-1:0] clkconf1,
        input logic [CODE_W-1:0] clkconf0
    );
        logic [CODE_W-1:0] codes [NCODES];
        codes[SLOT_NCONF1]   = nconf1;
        codes[SLOT_NCONF0]   = nconf0;
        codes[SLOT_PCONF1]   = pconf1;
        codes[SLOT_PCONF0]   = pconf0;
        codes[SLOT_CLKCONF1] = clkconf1;
        codes[SLOT_CLKCONF0] = clkconf0;
        pack_word = '0;
        for (int i = 0; i < NCODES; i++) begin
            pack_word[i*CODE_W +: CODE_W] = codes[i];
        end
    endfunction

endpackage

// File: rtl/rng_scan_tick.sv
// Scan-clock phase counter: counts CLK_DIV system cycles per phase and flags the last one.
module rng_scan_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_clr,
    output logic o_tc
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] TC_VAL = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;

    assign o_tc = (r_div_cnt == TC_VAL);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_div_cnt <= '0;
        end else if (i_clr || o_tc) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rng_conf_scan_tx.sv
// Serial configuration transmitter: shifts the six trim codes MSB-first into the analog
// scan chain, pulses the parallel latch, and optionally re-shifts while checking loopback.
module rng_conf_scan_tx
    import rng_cal_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int VERIFY  = 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              i_load,
    input  logic [CODE_W-1:0] i_nconf1,
    input  logic [CODE_W-1:0] i_nconf0,
    input  logic [CODE_W-1:0] i_pconf1,
    input  logic [CODE_W-1:0] i_pconf0,
    input  logic [CODE_W-1:0] i_clkconf1,
    input  logic [CODE_W-1:0] i_clkconf0,
    input  logic              i_scan_ret,
    output logic              o_scan_clk,
    output logic              o_scan_data,
    output logic              o_scan_latch,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_state_out
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(CHAIN_LEN - 1);

    cal_state_t             r_state, w_state_next;
    logic [CHAIN_LEN-1:0]   r_word, w_word_next;
    logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic                   r_pass, w_pass_next;
    logic                   r_err, w_err_next;
    logic                   r_scan_clk, r_scan_data, r_scan_latch, r_busy, r_done;
    logic                   w_scan_data_next;
    logic                   w_cur_bit;
    logic                   w_tc;
    logic                   w_tick_clr;

    // Phase counter idles at zero so the first SETUP phase is a full CLK_DIV long.
    assign w_tick_clr = (r_state == IDLE) || (r_state == DONE);

    rng_scan_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .resetb (resetb),
        .i_clr  (w_tick_clr),
        .o_tc   (w_tc)
    );

    assign w_cur_bit = r_word[LAST_BIT - r_bit_cnt];

    always_comb begin
        w_state_next   = r_state;
        w_word_next    = r_word;
        w_bit_cnt_next = r_bit_cnt;
        w_pass_next    = r_pass;
        w_err_next     = r_err;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_word_next    = pack_word(i_nconf1, i_nconf0, i_pconf1, i_pconf0,
                                               i_clkconf1, i_clkconf0);
                    w_err_next     = 1'b0;
                    w_bit_cnt_next = '0;
                    w_pass_next    = 1'b0;
                    w_state_next   = SETUP;
                end
            end
            SETUP: begin
                if (w_tc) begin
                    // In pass 1 the chain's tail holds the bit about to be re-shifted.
                    if (r_pass && (i_scan_ret != w_cur_bit)) begin
                        w_err_next = 1'b1;
                    end
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                if (w_tc) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = LATCH;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_state_next   = SETUP;
                    end
                end
            end
            LATCH: begin
                if (w_tc) begin
                    if ((VERIFY != 0) && !r_pass) begin
                        w_pass_next    = 1'b1;
                        w_bit_cnt_next = '0;
                        w_state_next   = SETUP;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_scan_data_next = 1'b0;
        if ((w_state_next == SETUP) || (w_state_next == HIGH)) begin
            w_scan_data_next = w_word_next[LAST_BIT - w_bit_cnt_next];
        end
    end

    // Outputs are decoded from the next state so they register in step with r_state.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_bit_cnt    <= '0;
            r_pass       <= 1'b0;
            r_err        <= 1'b0;
            r_scan_clk   <= 1'b0;
            r_scan_data  <= 1'b0;
            r_scan_latch <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word       <= w_word_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_pass       <= w_pass_next;
            r_err        <= w_err_next;
            r_scan_clk   <= (w_state_next == HIGH);
            r_scan_data  <= w_scan_data_next;
            r_scan_latch <= (w_state_next == LATCH);
            r_busy       <= (w_state_next != IDLE);
            r_done       <= (w_state_next == DONE);
        end
    end

    assign o_scan_clk   = r_scan_clk;
    assign o_scan_data  = r_scan_data;
    assign o_scan_latch = r_scan_latch;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_state_out  = r_state;

endmodule

// File: tb/tb_rng_conf_scan_tx.sv
// Bench for rng_conf_scan_tx: three instances (CLK_DIV/VERIFY = 4/0, 4/1, 1/1), each driving
// a behavioural 24-flop scan chain with loopback; latched words are checked via a scoreboard.
module tb_rng_conf_scan_tx;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0] load = '0;
    logic [23:0]     word_in [NDUT] = '{default: '0};
    logic [NDUT-1:0] scan_ret;
    logic [NDUT-1:0] scan_clk, scan_data, scan_latch, busy, done, err;
    logic [2:0]      state_out [NDUT];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        rng_conf_scan_tx #(
            .CLK_DIV ((gi == 2) ? 1 : 4),
            .VERIFY  ((gi == 0) ? 0 : 1)
        ) u_dut (
            .clk          (clk),
            .resetb       (resetb),
            .i_load       (load[gi]),
            .i_nconf1     (word_in[gi][23:20]),
            .i_nconf0     (word_in[gi][19:16]),
            .i_pconf1     (word_in[gi][15:12]),
            .i_pconf0     (word_in[gi][11:8]),
            .i_clkconf1   (word_in[gi][7:4]),
            .i_clkconf0   (word_in[gi][3:0]),
            .i_scan_ret   (scan_ret[gi]),
            .o_scan_clk   (scan_clk[gi]),
            .o_scan_data  (scan_data[gi]),
            .o_scan_latch (scan_latch[gi]),
            .o_busy       (busy[gi]),
            .o_done       (done[gi]),
            .o_err        (err[gi]),
            .o_state_out  (state_out[gi])
        );
    end

    // Analog chain model: shifts on scan_clk rise, latches on scan_latch rise.
    logic [23:0]     chain   [NDUT] = '{default: '0};
    logic [23:0]     latched [NDUT] = '{default: '0};
    int              rise_cnt   [NDUT] = '{default: 0};
    int              latch_cnt  [NDUT] = '{default: 0};
    int              done_cnt   [NDUT] = '{default: 0};
    int              corrupt_at [NDUT] = '{default: -1};
    logic [NDUT-1:0] sclk_prev = '0;
    logic [NDUT-1:0] latch_prev = '0;

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (scan_clk[i] && !sclk_prev[i]) begin
                chain[i]    <= {chain[i][22:0], scan_data[i]};
                rise_cnt[i] <= rise_cnt[i] + 1;
            end
            if (scan_latch[i] && !latch_prev[i]) begin
                latched[i]   <= chain[i];
                latch_cnt[i] <= latch_cnt[i] + 1;
            end
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
        sclk_prev  <= scan_clk;
        latch_prev <= scan_latch;
    end

    always_comb begin
        scan_ret = '0;
        for (int i = 0; i < NDUT; i++) begin
            scan_ret[i] = chain[i][23] ^ (rise_cnt[i] == corrupt_at[i]);
        end
    end

    typedef struct {
        int          idx;
        logic [23:0] word;
    } sb_t;
    sb_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Accepts a load at the next edge E0; returns at the negedge of cycle 0 with c0 = cyc.
    task automatic start_load(input int idx, input logic [23:0] w, output int c0);
        sb_t e;
        @(negedge clk);
        word_in[idx] = w;
        load[idx]    = 1'b1;
        @(negedge clk);
        load[idx]    = 1'b0;
        word_in[idx] = ~w;
        c0           = cyc;
        e.idx        = idx;
        e.word       = w;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int idx, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int k = 0; k < 2000; k++) begin
            if (done[idx]) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_latched(input int idx, input string name);
        sb_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_scoreboard: got empty queue, required one entry", name);
        end else begin
            e = sb_q.pop_front();
            if ((e.idx != idx) || (latched[idx] !== e.word)) begin
                n_bad++;
                $display("FAIL %s_latched: got dut%0d %h, required dut%0d %h",
                         name, idx, latched[idx], e.idx, e.word);
            end
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            n_cmp++;
            if ({scan_clk[i], scan_data[i], scan_latch[i], busy[i], done[i], err[i], state_out[i]} !== 9'd0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got %b, required 0", i,
                         {scan_clk[i], scan_data[i], scan_latch[i], busy[i], done[i], err[i], state_out[i]});
            end
        end
        resetb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_shift();
        int c0, at, lc0;
        bit ok;
        lc0 = latch_cnt[0];
        start_load(0, 24'hA53CF0, c0);
        wait_done(0, at, ok);
        n_cmp++;
        if (!ok || (at - c0) != 196) begin
            n_bad++;
            $display("FAIL basic_done_cycle: got %0d (seen=%0d), required 196", at - c0, ok);
        end
        n_cmp++;
        if (busy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy_at_done: got %b, required 1", busy[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || state_out[0] !== 3'd0) begin
            n_bad++;
            $display("FAIL basic_idle_after: got busy=%b state=%0d, required busy=0 state=0", busy[0], state_out[0]);
        end
        n_cmp++;
        if (latch_cnt[0] - lc0 != 1) begin
            n_bad++;
            $display("FAIL basic_latch_count: got %0d, required 1", latch_cnt[0] - lc0);
        end
        pop_latched(0, "basic");
        $display("load dut0 word=a53cf0 done_at=%0d latched=%h", at - c0, latched[0]);
    endtask

    task automatic test_verify_clean();
        int c0, at, lc0;
        bit ok;
        lc0 = latch_cnt[1];
        start_load(1, 24'h123456, c0);
        wait_done(1, at, ok);
        n_cmp++;
        if (!ok || (at - c0) != 392) begin
            n_bad++;
            $display("FAIL verify_done_cycle: got %0d (seen=%0d), required 392", at - c0, ok);
        end
        n_cmp++;
        if (err[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL verify_clean_err: got %b, required 0", err[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (chain[1] !== 24'h123456) begin
            n_bad++;
            $display("FAIL verify_chain: got %h, required 123456", chain[1]);
        end
        n_cmp++;
        if (latch_cnt[1] - lc0 != 2) begin
            n_bad++;
            $display("FAIL verify_latch_count: got %0d, required 2", latch_cnt[1] - lc0);
        end
        pop_latched(1, "verify_clean");
        $display("load dut1 word=123456 done_at=%0d err=%b chain=%h", at - c0, err[1], chain[1]);
    endtask

    task automatic test_verify_corrupt();
        int c0, at;
        bit ok;
        corrupt_at[1] = rise_cnt[1] + 31;
        start_load(1, 24'h9E37B1, c0);
        wait_done(1, at, ok);
        n_cmp++;
        if (!ok || err[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL corrupt_err_at_done: got %b (seen=%0d), required 1", err[1], ok);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (err[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL corrupt_err_sticky: got %b, required 1", err[1]);
        end
        pop_latched(1, "verify_corrupt");
        $display("load dut1 word=9e37b1 done_at=%0d err=%b (bit 7 loopback inverted)", at - c0, err[1]);
        corrupt_at[1] = -1;
        start_load(1, 24'h5A5A5A, c0);
        n_cmp++;
        if (err[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL corrupt_err_clear: got %b, required 0", err[1]);
        end
        wait_done(1, at, ok);
        n_cmp++;
        if (!ok || err[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_err: got %b (seen=%0d), required 0", err[1], ok);
        end
        @(negedge clk);
        pop_latched(1, "reload");
        $display("load dut1 word=5a5a5a done_at=%0d err=%b", at - c0, err[1]);
    endtask

    task automatic test_back_to_back();
        int c0, at, lc0, dc0;
        bit ok;
        lc0 = latch_cnt[0];
        dc0 = done_cnt[0];
        start_load(0, 24'h3C96E1, c0);
        while (cyc < c0 + 49) @(negedge clk);
        word_in[0] = 24'h000FFF;
        load[0]    = 1'b1;
        @(negedge clk);
        load[0]    = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b1 || state_out[0] === 3'd0) begin
            n_bad++;
            $display("FAIL busy_load_state: got busy=%b state=%0d, required busy=1 state!=0", busy[0], state_out[0]);
        end
        wait_done(0, at, ok);
        n_cmp++;
        if (!ok || (at - c0) != 196) begin
            n_bad++;
            $display("FAIL busy_load_done_cycle: got %0d (seen=%0d), required 196", at - c0, ok);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done_cnt[0] - dc0 != 1 || latch_cnt[0] - lc0 != 1) begin
            n_bad++;
            $display("FAIL busy_load_pulses: got done=%0d latch=%0d, required 1 and 1",
                     done_cnt[0] - dc0, latch_cnt[0] - lc0);
        end
        pop_latched(0, "busy_load");
        $display("load dut0 word=3c96e1 (second load at cycle 50 ignored) latched=%h", latched[0]);
    endtask

    task automatic test_clk_div1();
        int c0, at, lc0;
        bit ok;
        logic exp_clk;
        lc0 = latch_cnt[2];
        start_load(2, 24'hC3A517, c0);
        for (int k = 0; k < 8; k++) begin
            exp_clk = logic'(k % 2);
            n_cmp++;
            if (scan_clk[2] !== exp_clk) begin
                n_bad++;
                $display("FAIL div1_scan_clk cycle %0d: got %b, required %b", k, scan_clk[2], exp_clk);
            end
            @(negedge clk);
        end
        wait_done(2, at, ok);
        n_cmp++;
        if (!ok || (at - c0) != 98) begin
            n_bad++;
            $display("FAIL div1_done_cycle: got %0d (seen=%0d), required 98", at - c0, ok);
        end
        n_cmp++;
        if (err[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL div1_err: got %b, required 0", err[2]);
        end
        @(negedge clk);
        n_cmp++;
        if (latch_cnt[2] - lc0 != 2) begin
            n_bad++;
            $display("FAIL div1_latch_count: got %0d, required 2", latch_cnt[2] - lc0);
        end
        pop_latched(2, "div1");
        $display("load dut2 word=c3a517 done_at=%0d latched=%h", at - c0, latched[2]);
    endtask

    task automatic test_reset_mid_shift();
        int c0, lc0, dc0;
        sb_t e;
        start_load(1, 24'hFEDCBA, c0);
        while (cyc < c0 + 100) @(negedge clk);
        lc0 = latch_cnt[1];
        dc0 = done_cnt[1];
        resetb = 1'b0;
        #1;
        n_cmp++;
        if ({scan_clk[1], scan_data[1], scan_latch[1], busy[1], done[1], err[1], state_out[1]} !== 9'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b, required 0",
                     {scan_clk[1], scan_data[1], scan_latch[1], busy[1], done[1], err[1], state_out[1]});
        end
        repeat (4) @(negedge clk);
        resetb = 1'b1;
        repeat (450) @(negedge clk);
        n_cmp++;
        if (latch_cnt[1] != lc0 || done_cnt[1] != dc0 || state_out[1] !== 3'd0) begin
            n_bad++;
            $display("FAIL midreset_no_latch: got latch=%0d done=%0d state=%0d, required 0 0 0",
                     latch_cnt[1] - lc0, done_cnt[1] - dc0, state_out[1]);
        end
        if (sb_q.size() != 0) e = sb_q.pop_back();
        $display("load dut1 word=fedcba reset at cycle 100, state=%0d", state_out[1]);
    endtask

    initial begin
        test_reset();
        test_basic_shift();
        test_verify_clean();
        test_verify_corrupt();
        test_back_to_back();
        test_clk_div1();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
